dmem_dual_port: RTL and testbench
=================================

Name: dmem_dual_port

Overview:
Data-memory subsystem downstream of the dual-issue CPU core. It consumes the p0/p1 DM request ports (maddr, wdata, write_mem) and returns p0/p1 rdata. It contains a 2-port 16-bit RAM plus a small memory-mapped I/O window: LEDs, synchronised switches and a 32-bit cycle counter. Same-cycle port interactions are resolved in program order, so p0 is older than p1.

Parameters:
RAM_WORDS, 256, number of 16-bit RAM words mapped at 0x000..RAM_WORDS-1 (must be ≤256).
SW_WIDTH, 10, width of switch input.
LED_WIDTH, 10, width of LED register.

Ports:
clk  in  1  clock
rst  in  1  reset
p0_maddr  in  9  p0 word address
p0_wdata  in  16  p0 store data
p0_write_mem  in  1  p0 store strobe
p0_rdata  out  16  p0 load data, valid 1 cycle after address
p1_maddr  in  9  p1 word address
p1_wdata  in  16  p1 store data
p1_write_mem  in  1  p1 store strobe
p1_rdata  out  16  p1 load data, valid 1 cycle after address
sw_in  in  SW_WIDTH  asynchronous switches
led_out  out  LED_WIDTH  LED register

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: p0_rdata=0, p1_rdata=0, led_out=0, counter=0, counter shadow=0, switch synchroniser=0. RAM contents are not reset.
- Address map:
  - 0x000..RAM_WORDS-1: RAM.
  - 0x100: LED register. R/W; low LED_WIDTH bits are used, reads are zero-extended.
  - 0x101: switches. Read-only; value after the 2-flop synchroniser, zero-extended.
  - 0x102: counter[15:0]. A read also latches counter[31:16] into the shadow. Any write clears the counter.
  - 0x103: shadow[15:0]. Read-only.
  - All other addresses: reads return 0; writes are ignored.
- Read latency: every port samples its maddr on each posedge; rdata is registered and holds until the next edge. There is no enable; reads occur every cycle.
- Same-port read+write: rdata after the edge equals the wdata just written (write-first).
- Cross-port, same address, same cycle:
  - p0 writes, p1 reads: p1_rdata = p0_wdata (p1 is younger, so it sees the store).
  - p1 writes, p0 reads: p0_rdata = old contents (p0 is older, so it does not see the store).
  - Both write: stored value = p1_wdata. Each port's own rdata follows the rules above, so p0_rdata=p1_wdata? No: p0_rdata = p0_wdata, p1_rdata = p1_wdata.
- Counter: 32-bit, increments every cycle and wraps 0xFFFFFFFF→0.
  - A write to 0x102 from either or both ports makes the counter 0 after that edge; clear takes priority over increment.
  - A read of 0x102 returns the pre-edge counter low half; the shadow gets the pre-edge high half.
  - p0 reads 0x102 while p1 reads 0x103 in the same cycle: p1 gets the high half of the same sample (shadow bypassed).
  - p1 reads 0x102 while p0 reads 0x103 in the same cycle: p0 gets the old shadow.
- LED register: if both ports write 0x100 in the same cycle, p1 wins.
- Out-of-range RAM indices (RAM_WORDS..0x0FF when RAM_WORDS<256) behave as unmapped.
- Reset asserted mid-operation: rdata, LED and counter are forced to their reset values that edge. RAM writes presented in the reset cycle are still performed.

Decomposition:
- Package dmem_pkg holds:
  - address constants: ADDR_LED=9'h100, ADDR_SW=9'h101, ADDR_CNT_LO=9'h102, ADDR_CNT_HI=9'h103;
  - the region-decode enum {REG_RAM, REG_LED, REG_SW, REG_CNTLO, REG_CNTHI, REG_NONE};
  - the decode function.
- One sub-module, dmem_ram_2p: the 2-write/2-read RAM implementing the p1-priority write and the cross-port bypass rules.
- MMIO registers and the counter live in the top module.

Test Plan:
- Store then load: p0 writes 0x1234 to addr 5 in cycle 0; p0 reads addr 5 in cycle 1 → p0_rdata=0x1234 after cycle 2's edge; p1 read of addr 5 in cycle 1 also gives 0x1234.
- Cross-port bypass:
  - p0 writes 0xAAAA to addr 7 while p1 reads addr 7 in the same cycle → p1_rdata=0xAAAA next cycle.
  - Swapped roles (p1 writes 0xBBBB, p0 reads, old value 0xAAAA) → p0_rdata=0xAAAA; a later read of addr 7 returns 0xBBBB.
- Dual write conflict: p0 writes 0x1111 and p1 writes 0x2222 to addr 9 in the same cycle → subsequent read of addr 9 = 0x2222; LED dual write 0x3/0x5 → led_out=0x005.
- Counter: release reset, wait 0x1_0005 cycles, p0 reads 0x102 and p1 reads 0x103 in the same cycle → p0_rdata=0x0005 and p1_rdata=0x0001 (pre-edge sample); then p0 writes 0x102 → the following read of 0x102 returns 0x0000 plus elapsed cycles.
- Switches/unmapped: sw_in=0x2A5 held → a read of 0x101 issued ≥2 cycles later returns 0x02A5; a read of 0x1F0 returns 0; a write to 0x1F0 changes no RAM or register.
- Reset mid-run: assert rst with led_out=0x3FF and counter nonzero → after that edge, led_out=0, rdata=0 and counter=0; RAM addr 5 still holds 0x1234.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map and region decode for the dual-port data memory.
package dmem_pkg;

    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h101;
    localparam logic [8:0] ADDR_CNT_LO = 9'h102;
    localparam logic [8:0] ADDR_CNT_HI = 9'h103;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_CNTLO,
        REG_CNTHI,
        REG_NONE
    } region_t;

    // RAM occupies the lower half of the map; indices past ram_words are unmapped.
    function automatic region_t decode(input logic [8:0] addr, input int unsigned ram_words);
        region_t r;
        r = REG_NONE;
        if (!addr[8]) begin
            if (32'(addr[7:0]) < ram_words) r = REG_RAM;
        end else begin
            case (addr)
                ADDR_LED:    r = REG_LED;
                ADDR_SW:     r = REG_SW;
                ADDR_CNT_LO: r = REG_CNTLO;
                ADDR_CNT_HI: r = REG_CNTHI;
                default:     r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram_2p.sv
// Two-write/two-read 16-bit RAM; p0 is the older port, so p1 wins write
// conflicts and sees p0's same-cycle store, while p0 never sees p1's store.
module dmem_ram_2p #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic [7:0]  p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic        p0_we,
    input  logic [7:0]  p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic        p1_we,
    output logic [15:0] p0_rd,
    output logic [15:0] p1_rd
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [15:0]   mem [WORDS];
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;

    assign a0 = p0_addr[AW-1:0];
    assign a1 = p1_addr[AW-1:0];

    // Later assignment wins, giving p1 priority on a same-address double store.
    always_ff @(posedge clk) begin
        if (p0_we) mem[a0] <= p0_wdata;
        if (p1_we) mem[a1] <= p1_wdata;
    end

    always_comb begin
        p0_rd = p0_we ? p0_wdata : mem[a0];
        p1_rd = mem[a1];
        if (p1_we)                     p1_rd = p1_wdata;
        else if (p0_we && (a0 == a1))  p1_rd = p0_wdata;
    end

endmodule

// File: rtl/dmem_dual_port.sv
// Data-memory subsystem: 2-port RAM plus LED, switch and cycle-counter MMIO,
// with same-cycle interactions resolved in program order (p0 before p1).
module dmem_dual_port
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int SW_WIDTH  = 10,
    parameter int LED_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:0]           p0_maddr,
    input  logic [15:0]          p0_wdata,
    input  logic                 p0_write_mem,
    output logic [15:0]          p0_rdata,
    input  logic [8:0]           p1_maddr,
    input  logic [15:0]          p1_wdata,
    input  logic                 p1_write_mem,
    output logic [15:0]          p1_rdata,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out
);

    region_t reg0, reg1;
    logic [15:0] ram_rd0, ram_rd1;
    logic [15:0] rd_next0, rd_next1;
    logic [LED_WIDTH-1:0] led_view0, led_view1;
    logic [SW_WIDTH-1:0]  sw_meta, sw_sync;
    logic [31:0] cnt;
    logic [15:0] shadow;
    logic led_wr0, led_wr1, cnt_clr, cnt_rd_lo;

    always_comb begin
        reg0 = decode(p0_maddr, RAM_WORDS);
        reg1 = decode(p1_maddr, RAM_WORDS);
    end

    // RAM stores are not gated by rst: RAM contents survive reset.
    dmem_ram_2p #(.WORDS(RAM_WORDS)) u_ram (
        .clk      (clk),
        .p0_addr  (p0_maddr[7:0]),
        .p0_wdata (p0_wdata),
        .p0_we    (p0_write_mem && (reg0 == REG_RAM)),
        .p1_addr  (p1_maddr[7:0]),
        .p1_wdata (p1_wdata),
        .p1_we    (p1_write_mem && (reg1 == REG_RAM)),
        .p0_rd    (ram_rd0),
        .p1_rd    (ram_rd1)
    );

    assign led_wr0   = p0_write_mem && (reg0 == REG_LED);
    assign led_wr1   = p1_write_mem && (reg1 == REG_LED);
    assign cnt_clr   = (p0_write_mem && (reg0 == REG_CNTLO)) || (p1_write_mem && (reg1 == REG_CNTLO));
    assign cnt_rd_lo = (reg0 == REG_CNTLO) || (reg1 == REG_CNTLO);

    // Each port's view of the LED register after its own and any older store.
    always_comb begin
        led_view0 = led_wr0 ? p0_wdata[LED_WIDTH-1:0] : led_out;
        led_view1 = led_view0;
        if (led_wr1) led_view1 = p1_wdata[LED_WIDTH-1:0];
    end

    always_comb begin
        rd_next0 = 16'h0000;
        case (reg0)
            REG_RAM:   rd_next0 = ram_rd0;
            REG_LED:   rd_next0 = 16'(led_view0);
            REG_SW:    rd_next0 = 16'(sw_sync);
            REG_CNTLO: rd_next0 = cnt[15:0];
            REG_CNTHI: rd_next0 = shadow;
            default:   rd_next0 = 16'h0000;
        endcase
    end

    // p1 is younger: a same-cycle p0 counter read refreshes the shadow it sees.
    always_comb begin
        rd_next1 = 16'h0000;
        case (reg1)
            REG_RAM:   rd_next1 = ram_rd1;
            REG_LED:   rd_next1 = 16'(led_view1);
            REG_SW:    rd_next1 = 16'(sw_sync);
            REG_CNTLO: rd_next1 = cnt[15:0];
            REG_CNTHI: rd_next1 = (reg0 == REG_CNTLO) ? cnt[31:16] : shadow;
            default:   rd_next1 = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rdata <= 16'h0000;
            p1_rdata <= 16'h0000;
            led_out  <= '0;
            cnt      <= 32'h0;
            shadow   <= 16'h0000;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            p0_rdata <= rd_next0;
            p1_rdata <= rd_next1;
            led_out  <= led_view1;
            cnt      <= cnt_clr ? 32'h0 : cnt + 32'h1;
            if (cnt_rd_lo) shadow <= cnt[31:16];
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

endmodule

// File: tb/tb_dmem_dual_port.sv
// Self-checking bench for dmem_dual_port: each cycle is replayed on a program-order
// model (p0's access completes, then p1's) and compared against the DUT.
module tb_dmem_dual_port;

    logic        clk;
    logic        rst;
    logic [8:0]  p0_maddr, p1_maddr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_write_mem, p1_write_mem;
    logic [15:0] p0_rdata, p1_rdata;
    logic [9:0]  sw_in;
    logic [9:0]  led_out;

    int checks;
    int failures;

    logic [15:0] mem_m [256];
    logic [9:0]  led_m;
    logic [31:0] cnt_m;
    logic [15:0] shadow_m;
    logic [9:0]  sw_d1, sw_d2;
    logic [31:0] pre_cnt;
    logic [9:0]  sw_pre;
    logic        clr;
    logic [15:0] e0, e1;

    dmem_dual_port #(.RAM_WORDS(256), .SW_WIDTH(10), .LED_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_maddr     (p0_maddr),
        .p0_wdata     (p0_wdata),
        .p0_write_mem (p0_write_mem),
        .p0_rdata     (p0_rdata),
        .p1_maddr     (p1_maddr),
        .p1_wdata     (p1_wdata),
        .p1_write_mem (p1_write_mem),
        .p1_rdata     (p1_rdata),
        .sw_in        (sw_in),
        .led_out      (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One access in program order against the model state.
    task automatic access(input logic [8:0] a, input logic [15:0] d, input logic w,
                          output logic [15:0] rd);
        rd = 16'h0000;
        if (a < 9'd256) begin
            if (w) mem_m[a[7:0]] = d;
            rd = mem_m[a[7:0]];
        end else if (a == 9'h100) begin
            if (w) led_m = d[9:0];
            rd = {6'b0, led_m};
        end else if (a == 9'h101) begin
            rd = {6'b0, sw_pre};
        end else if (a == 9'h102) begin
            if (w) clr = 1'b1;
            shadow_m = pre_cnt[31:16];
            rd = pre_cnt[15:0];
        end else if (a == 9'h103) begin
            rd = shadow_m;
        end
    endtask

    task automatic step(input logic [8:0] a0, input logic [15:0] d0, input logic w0,
                        input logic [8:0] a1, input logic [15:0] d1, input logic w1,
                        input logic r, input bit chk);
        logic [15:0] dummy;
        p0_maddr = a0; p0_wdata = d0; p0_write_mem = w0;
        p1_maddr = a1; p1_wdata = d1; p1_write_mem = w1;
        rst = r;
        @(posedge clk);
        pre_cnt = cnt_m;
        sw_pre  = sw_d2;
        clr     = 1'b0;
        if (r) begin
            if (w0 && a0 < 9'd256) mem_m[a0[7:0]] = d0;
            if (w1 && a1 < 9'd256) mem_m[a1[7:0]] = d1;
            e0 = 16'h0; e1 = 16'h0;
            led_m = '0; cnt_m = 32'h0; shadow_m = 16'h0;
            sw_d1 = '0; sw_d2 = '0;
        end else begin
            access(a0, d0, w0, dummy); e0 = dummy;
            access(a1, d1, w1, dummy); e1 = dummy;
            cnt_m = clr ? 32'h0 : pre_cnt + 32'h1;
            sw_d2 = sw_d1;
            sw_d1 = sw_in;
        end
        #1;
        if (chk) begin
            check16("p0_rdata", p0_rdata, e0);
            check16("p1_rdata", p1_rdata, e1);
            check16("led_out", {6'b0, led_out}, {6'b0, led_m});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(9'h1F0, 16'h0, 1'b0, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [8:0] rand_addr();
        logic [8:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = 9'($urandom_range(0, 15));
            6, 9:             a = 9'h100 + 9'($urandom_range(0, 3));
            7:                a = 9'h1F0;
            default:          a = 9'($urandom_range(0, 511));
        endcase
        return a;
    endfunction

    initial begin
        checks = 0; failures = 0;
        sw_in = '0;
        led_m = '0; cnt_m = 32'h0; shadow_m = 16'h0; sw_d1 = '0; sw_d2 = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;

        // Reset state
        step(9'h0, 16'h0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        step(9'h0, 16'h0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b1, 1'b1);

        // Give every RAM word a known value
        for (int i = 0; i < 128; i++)
            step(9'(2 * i), 16'($urandom), 1'b1, 9'(2 * i + 1), 16'($urandom), 1'b1, 1'b0, 1'b1);

        // Store then load
        step(9'd5, 16'h1234, 1'b1, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(9'd5, 16'h0, 1'b0, 9'd5, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("store_load_p0", p0_rdata, 16'h1234);
        check16("store_load_p1", p1_rdata, 16'h1234);

        // Cross-port bypass both ways
        step(9'd7, 16'hAAAA, 1'b1, 9'd7, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("bypass_p0_to_p1", p1_rdata, 16'hAAAA);
        step(9'd7, 16'h0, 1'b0, 9'd7, 16'hBBBB, 1'b1, 1'b0, 1'b1);
        check16("no_bypass_p1_to_p0", p0_rdata, 16'hAAAA);
        step(9'd7, 16'h0, 1'b0, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("after_p1_store", p0_rdata, 16'hBBBB);

        // Dual write conflicts
        step(9'd9, 16'h1111, 1'b1, 9'd9, 16'h2222, 1'b1, 1'b0, 1'b1);
        step(9'd9, 16'h0, 1'b0, 9'd9, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("dual_write_ram", p0_rdata, 16'h2222);
        step(9'h100, 16'h0003, 1'b1, 9'h100, 16'h0005, 1'b1, 1'b0, 1'b1);
        check16("dual_write_led", {6'b0, led_out}, 16'h0005);

        // Switches and unmapped space
        sw_in = 10'h2A5;
        idle(2);
        step(9'h101, 16'h0, 1'b0, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("switch_read", p0_rdata, 16'h02A5);
        step(9'h1F0, 16'h0, 1'b0, 9'h1F0, 16'hDEAD, 1'b1, 1'b0, 1'b1);
        check16("unmapped_read", p0_rdata, 16'h0000);
        step(9'd5, 16'h0, 1'b0, 9'h100, 16'h0, 1'b0, 1'b0, 1'b1);

        // Counter: long run, paired low/high sample, then clear
        step(9'h1F0, 16'h0, 1'b0, 9'h1F0, 16'h0, 1'b0, 1'b1, 1'b1);
        idle(32'h1_0005);
        step(9'h102, 16'h0, 1'b0, 9'h103, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("cnt_lo_sample", p0_rdata, 16'h0005);
        check16("cnt_hi_same_sample", p1_rdata, 16'h0001);
        step(9'h102, 16'h0, 1'b1, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(9'h102, 16'h0, 1'b0, 9'h103, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("cnt_after_clear", p0_rdata, 16'h0003);
        check16("cnt_hi_after_clear", p1_rdata, 16'h0000);

        // Reset mid-run
        step(9'h100, 16'h03FF, 1'b1, 9'h1F0, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("led_set", {6'b0, led_out}, 16'h03FF);
        step(9'h100, 16'h0, 1'b0, 9'd5, 16'h0, 1'b0, 1'b1, 1'b1);
        check16("rst_led", {6'b0, led_out}, 16'h0000);
        check16("rst_p0_rdata", p0_rdata, 16'h0000);
        check16("rst_p1_rdata", p1_rdata, 16'h0000);
        step(9'h102, 16'h0, 1'b0, 9'd5, 16'h0, 1'b0, 1'b0, 1'b1);
        check16("rst_cnt", p0_rdata, 16'h0000);
        check16("ram_survives_rst", p1_rdata, 16'h1234);

        // Randomized traffic with dense address collisions
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom_range(0, 1023));
            step(rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                 rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
